// File: rtl/ppu_pkg.sv
// Shared PPU types and helpers: accumulator FSM encoding and a width-generic
// saturating adder used by the accumulation stage.
package ppu_pkg;

  // Default width of the core-ops fixed-point word.
  localparam int FX_B           = 16;
  localparam int ACC_GUARD_BITS = 8;

  // The adder works on operands sign-extended to this width so that one
  // function serves any accumulator width up to SAT_MAX_W bits.
  localparam int SAT_MAX_W = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } acc_state_e;

  typedef struct packed {
    logic signed [SAT_MAX_W-1:0] sum;
    logic                        ovf;
  } sat_res_t;

  // a and b must already lie inside the signed acc_w-bit range; the sum is
  // exact one bit wider, then clamped to that range.
  function automatic sat_res_t sat_add(input logic signed [SAT_MAX_W-1:0] a,
                                       input logic signed [SAT_MAX_W-1:0] b,
                                       input int unsigned                 acc_w);
    logic signed [SAT_MAX_W:0] s;
    logic signed [SAT_MAX_W:0] hi;
    logic signed [SAT_MAX_W:0] lo;
    sat_res_t                  r;
    s  = $signed({a[SAT_MAX_W-1], a}) + $signed({b[SAT_MAX_W-1], b});
    hi = ($signed({{SAT_MAX_W{1'b0}}, 1'b1}) <<< (acc_w - 1)) - $signed({{SAT_MAX_W{1'b0}}, 1'b1});
    lo = ~hi;
    if (s > hi) begin
      r.sum = hi[SAT_MAX_W-1:0];
      r.ovf = 1'b1;
    end else if (s < lo) begin
      r.sum = lo[SAT_MAX_W-1:0];
      r.ovf = 1'b1;
    end else begin
      r.sum = s[SAT_MAX_W-1:0];
      r.ovf = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/ppu_fixed_accumulator.sv
// Accumulates a stream of signed fixed-point products into a guard-extended,
// saturating register and hands the final sum downstream via valid/ready.
module ppu_fixed_accumulator
  import ppu_pkg::*;
#(
  parameter  int FX_W       = FX_B,
  parameter  int GUARD_BITS = ACC_GUARD_BITS,
  parameter  int CNT_W      = 16,
  localparam int ACC_W      = FX_W + GUARD_BITS
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [FX_W-1:0]  fixed_i,
  input  logic             valid_i,
  input  logic             last_i,
  input  logic             clear_i,
  output logic             ready_o,
  output logic [ACC_W-1:0] acc_o,
  output logic             acc_valid_o,
  input  logic             acc_ready_i,
  output logic [CNT_W-1:0] count_o,
  output logic             overflow_o
);

  acc_state_e       state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             valid_q;
  logic             beat;

  logic [SAT_MAX_W-1:0] acc_wide;
  logic [SAT_MAX_W-1:0] fx_wide;
  sat_res_t             add_res;
  logic                 unused_ok;

  assign ready_o = (state_q != DONE);
  assign beat    = valid_i && ready_o;

  assign fx_wide  = {{(SAT_MAX_W-FX_W){fixed_i[FX_W-1]}}, fixed_i};
  assign acc_wide = {{(SAT_MAX_W-ACC_W){acc_q[ACC_W-1]}}, acc_q};
  assign add_res  = sat_add(acc_wide, fx_wide, ACC_W);
  // After clamping, the bits above ACC_W are pure sign copies.
  assign unused_ok = ^add_res.sum[SAT_MAX_W-1:ACC_W];

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    if (clear_i) begin
      state_d = IDLE;
      acc_d   = '0;
      count_d = '0;
      ovf_d   = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: if (beat) begin
          acc_d   = fx_wide[ACC_W-1:0];
          count_d = CNT_W'(1);
          ovf_d   = 1'b0;
          state_d = last_i ? DONE : ACCUM;
        end
        ACCUM: if (beat) begin
          acc_d   = add_res.sum[ACC_W-1:0];
          ovf_d   = ovf_q | add_res.ovf;
          count_d = (&count_q) ? count_q : count_q + CNT_W'(1);
          if (last_i) state_d = DONE;
        end
        DONE: if (acc_ready_i) begin
          state_d = IDLE;
          acc_d   = '0;
          count_d = '0;
          ovf_d   = 1'b0;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      acc_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      valid_q <= (state_d == DONE);
    end
  end

  assign acc_o       = acc_q;
  assign count_o     = count_q;
  assign overflow_o  = ovf_q;
  assign acc_valid_o = valid_q;

endmodule
